// File: rtl/hack_memory_responder_pkg.sv
// Shared address map, region decode and screen-entry payload for the Hack data-memory responder.
package hack_memory_responder_pkg;

   localparam int unsigned ADDR_W    = 15;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned RAM_AW    = 14;
   localparam int unsigned SCR_AW    = 13;
   localparam int unsigned RAM_WORDS = 1 << RAM_AW;
   localparam int unsigned SCR_WORDS = 1 << SCR_AW;

   localparam logic [ADDR_W-1:0] RAM_BASE    = 15'h0000;
   localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
   localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_SCREEN,
      REG_KBD,
      REG_NONE
   } region_e;

   typedef struct packed {
      logic [SCR_AW-1:0] addr;
      logic [DATA_W-1:0] data;
   } scr_entry_t;

   // Map a CPU word address onto its Hack memory region.
   function automatic region_e decode_region(input logic [ADDR_W-1:0] a);
      region_e r;
      if (a < SCREEN_BASE)   r = REG_RAM;
      else if (a < KBD_ADDR) r = REG_SCREEN;
      else if (a == KBD_ADDR) r = REG_KBD;
      else                   r = REG_NONE;
      return r;
   endfunction

endpackage

// File: rtl/hack_screen_fifo.sv
// First-word-fall-through sync FIFO carrying screen writes to the display controller.
module hack_screen_fifo
   import hack_memory_responder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  scr_entry_t i_push_data,
   output logic       o_full,
   output logic       o_valid,
   input  logic       i_ready,
   output scr_entry_t o_head
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   scr_entry_t       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;
   logic             w_push_ok;

   assign o_valid   = (r_count != '0);
   assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign o_head    = r_mem[r_rd_ptr];
   assign w_pop     = o_valid & i_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
   assign w_push_ok = i_push & (~o_full | w_pop);

   // Pointer and occupancy tracking; reset discards any queued entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/hack_memory_responder.sv
// Hack CPU data-memory responder: RAM, screen with write FIFO, and keyboard register.
module hack_memory_responder
   import hack_memory_responder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memory_write,
   input  logic [ADDR_W-1:0] memory_address,
   input  logic [DATA_W-1:0] memory_out,
   output logic [DATA_W-1:0] memory_in,
   input  logic              kbd_valid,
   input  logic [DATA_W-1:0] kbd_code,
   output logic              kbd_ready,
   output logic              scr_valid,
   input  logic              scr_ready,
   output logic [SCR_AW-1:0] scr_addr,
   output logic [DATA_W-1:0] scr_data,
   output logic              scr_overflow
);

   logic [DATA_W-1:0] r_ram    [RAM_WORDS];
   logic [DATA_W-1:0] r_screen [SCR_WORDS];
   logic [DATA_W-1:0] r_key;
   logic              r_overflow;

   region_e           w_region;
   logic [RAM_AW-1:0] w_ram_idx;
   logic [SCR_AW-1:0] w_scr_idx;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   scr_entry_t        w_push_data;
   scr_entry_t        w_head;

   assign w_region    = decode_region(memory_address);
   assign w_ram_idx   = RAM_AW'(memory_address - RAM_BASE);
   assign w_scr_idx   = SCR_AW'(memory_address - SCREEN_BASE);
   // Reset still lets the arrays commit but must not queue anything.
   assign w_push      = memory_write & (w_region == REG_SCREEN) & ~reset;
   assign w_pop       = scr_valid & scr_ready;
   assign w_push_data = '{addr: w_scr_idx, data: memory_out};

   assign kbd_ready    = 1'b1;
   assign scr_overflow = r_overflow;
   assign scr_addr     = w_head.addr;
   assign scr_data     = w_head.data;

   // Zero-latency read mux; array reads see pre-edge contents.
   always_comb begin
      memory_in = '0;
      case (w_region)
         REG_RAM:    memory_in = r_ram[w_ram_idx];
         REG_SCREEN: memory_in = r_screen[w_scr_idx];
         REG_KBD:    memory_in = r_key;
         default:    memory_in = '0;
      endcase
   end

   // RAM and screen array writes; the keyboard address and above are read-only.
   always_ff @(posedge clk) begin
      if (memory_write) begin
         case (w_region)
            REG_RAM:    r_ram[w_ram_idx]    <= memory_out;
            REG_SCREEN: r_screen[w_scr_idx] <= memory_out;
            default:    ;
         endcase
      end
   end

   // Keyboard capture and sticky overflow flag for dropped screen writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_key      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (kbd_valid)                   r_key      <= kbd_code;
         if (w_push && w_full && !w_pop)  r_overflow <= 1'b1;
      end
   end

   hack_screen_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_screen_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .o_full      (w_full),
      .o_valid     (scr_valid),
      .i_ready     (scr_ready),
      .o_head      (w_head)
   );

endmodule

// File: tb/tb_hack_memory_responder.sv
// Self-checking bench for hack_memory_responder: directed scenarios then randomized traffic vs. a queue/array model.
module tb_hack_memory_responder;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        memory_write;
   logic [14:0] memory_address;
   logic [15:0] memory_out;
   logic [15:0] memory_in;
   logic        kbd_valid;
   logic [15:0] kbd_code;
   logic        kbd_ready;
   logic        scr_valid;
   logic        scr_ready;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;
   logic        scr_overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   logic [15:0] m_ram [int];
   logic [15:0] m_scr [int];
   logic [15:0] m_key;
   logic        m_ovf;
   logic [28:0] m_q [$];

   always #5 clk = ~clk;

   hack_memory_responder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .memory_write   (memory_write),
      .memory_address (memory_address),
      .memory_out     (memory_out),
      .memory_in      (memory_in),
      .kbd_valid      (kbd_valid),
      .kbd_code       (kbd_code),
      .kbd_ready      (kbd_ready),
      .scr_valid      (scr_valid),
      .scr_ready      (scr_ready),
      .scr_addr       (scr_addr),
      .scr_data       (scr_data),
      .scr_overflow   (scr_overflow)
   );

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic model_known(input logic [14:0] a);
      if (a < 15'h4000)      return m_ram.exists(int'(a));
      else if (a < 15'h6000) return m_scr.exists(int'(a[12:0]));
      else                   return 1'b1;
   endfunction

   function automatic logic [15:0] model_read(input logic [14:0] a);
      if (a < 15'h4000)       return m_ram[int'(a)];
      else if (a < 15'h6000)  return m_scr[int'(a[12:0])];
      else if (a == 15'h6000) return m_key;
      else                    return 16'h0000;
   endfunction

   // Compare every observable output against the model for the currently driven inputs.
   task automatic check_all(input string tag);
      if (model_known(memory_address))
         chk16({tag, "/rd"}, memory_in, model_read(memory_address));
      chk1({tag, "/valid"}, scr_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         chk16({tag, "/saddr"}, 16'(scr_addr), 16'(m_q[0][28:16]));
         chk16({tag, "/sdata"}, scr_data, m_q[0][15:0]);
      end
      chk1({tag, "/ovf"}, scr_overflow, m_ovf);
      chk1({tag, "/kready"}, kbd_ready, 1'b1);
   endtask

   // Apply one clock edge to the model using the inputs as sampled at that edge.
   task automatic model_clock();
      logic pop, full;
      pop  = (m_q.size() != 0) && scr_ready;
      full = (m_q.size() == DEPTH);
      if (memory_write && memory_address < 15'h4000)
         m_ram[int'(memory_address)] = memory_out;
      else if (memory_write && memory_address < 15'h6000)
         m_scr[int'(memory_address - 15'h4000)] = memory_out;
      if (reset) begin
         m_q.delete();
         m_key = 16'h0000;
         m_ovf = 1'b0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (memory_write && memory_address >= 15'h4000 && memory_address < 15'h6000) begin
            if (!full || pop) m_q.push_back({13'(memory_address - 15'h4000), memory_out});
            else              m_ovf = 1'b1;
         end
         if (kbd_valid) m_key = kbd_code;
      end
   endtask

   task automatic drive(input string tag, input logic rst, input logic w, input logic [14:0] a,
                        input logic [15:0] d, input logic kv, input logic [15:0] kc, input logic rdy);
      reset          = rst;
      memory_write   = w;
      memory_address = a;
      memory_out     = d;
      kbd_valid      = kv;
      kbd_code       = kc;
      scr_ready      = rdy;
      #1;
      check_all(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   function automatic logic [14:0] rand_addr();
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return 15'($urandom_range(0, 31));
         4, 5, 6, 7: return 15'(15'h4000 + 15'($urandom_range(0, 31)));
         8:          return 15'(15'h6000 + 15'($urandom_range(0, 3)));
         default:    return 15'($urandom_range(15'h6001, 15'h7FFF));
      endcase
   endfunction

   initial begin
      m_key = 16'h0000;
      m_ovf = 1'b0;
      reset = 1'b1; memory_write = 1'b0; memory_address = '0; memory_out = '0;
      kbd_valid = 1'b0; kbd_code = '0; scr_ready = 1'b0;
      @(negedge clk);
      tick();
      tick();

      // Reset state
      drive("rst", 0, 0, 15'h6000, 0, 0, 0, 0);
      chk1("rst_valid", scr_valid, 1'b0);
      chk1("rst_ovf", scr_overflow, 1'b0);
      chk16("rst_key", memory_in, 16'h0000);
      tick();

      // RAM read-during-write returns old data, new data next cycle
      drive("w5a", 0, 1, 15'h0005, 16'hAAAA, 0, 0, 0); tick();
      drive("w5b", 0, 1, 15'h0005, 16'h1234, 0, 0, 0);
      chk16("rdw_old", memory_in, 16'hAAAA);
      tick();
      drive("r5", 0, 0, 15'h0005, 0, 0, 0, 0);
      chk16("rd_new", memory_in, 16'h1234);
      tick();

      // Screen write lands in the FIFO one cycle later
      drive("ws", 0, 1, 15'h4001, 16'hFFFF, 0, 0, 0);
      chk1("ws_empty", scr_valid, 1'b0);
      tick();
      drive("ws_chk", 0, 0, 15'h4001, 0, 0, 0, 0);
      chk1("ws_valid", scr_valid, 1'b1);
      chk16("ws_addr", 16'(scr_addr), 16'h0001);
      chk16("ws_data", scr_data, 16'hFFFF);
      chk16("ws_rd", memory_in, 16'hFFFF);
      tick();
      drive("ws_pop", 0, 0, 15'h0, 0, 0, 0, 1); tick();
      drive("ws_done", 0, 0, 15'h0, 0, 0, 0, 0);
      chk1("ws_drained", scr_valid, 1'b0);
      tick();

      // Full FIFO with simultaneous pop and push: nothing dropped
      for (int i = 1; i <= 8; i++) begin
         drive("fill", 0, 1, 15'(15'h4000 + i), 16'(16'h0100 + i), 0, 0, 0); tick();
      end
      drive("fullpp", 0, 1, 15'h4010, 16'h0200, 0, 0, 1);
      chk16("fullpp_head", scr_data, 16'h0101);
      tick();
      drive("fullpp_chk", 0, 0, 15'h0, 0, 0, 0, 0);
      chk1("fullpp_ovf", scr_overflow, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         logic [15:0] exp_d;
         exp_d = (i < 7) ? 16'(16'h0102 + i) : 16'h0200;
         drive("fullpp_drain", 0, 0, 15'h0, 0, 0, 0, 1);
         chk1("fpd_valid", scr_valid, 1'b1);
         chk16("fpd_data", scr_data, exp_d);
         tick();
      end
      drive("fullpp_empty", 0, 0, 15'h0, 0, 0, 0, 0);
      chk1("fpd_empty", scr_valid, 1'b0);
      tick();

      // Overflow: nine writes into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) begin
         drive("ovf_fill", 0, 1, 15'(15'h4000 + i), 16'(i), 0, 0, 0); tick();
      end
      drive("ovf_chk", 0, 0, 15'h0, 0, 0, 0, 0);
      chk1("ovf_flag", scr_overflow, 1'b1);
      chk16("ovf_head", scr_data, 16'h0001);
      tick();
      for (int i = 1; i <= 8; i++) begin
         drive("ovf_drain", 0, 0, 15'h0, 0, 0, 0, 1);
         chk16("ovf_d_addr", 16'(scr_addr), 16'(i));
         chk16("ovf_d_data", scr_data, 16'(i));
         tick();
      end
      drive("ovf_empty", 0, 0, 15'h4009, 0, 0, 0, 0);
      chk1("ovf_empty_valid", scr_valid, 1'b0);
      chk1("ovf_sticky", scr_overflow, 1'b1);
      chk16("ovf_scr9", memory_in, 16'h0009);
      tick();

      // Keyboard register load, read-only behaviour, unmapped reads
      drive("kbd", 0, 0, 15'h6000, 0, 1, 16'h0083, 0); tick();
      drive("kbd_w", 0, 1, 15'h6000, 16'h5555, 0, 0, 0);
      chk16("kbd_rd", memory_in, 16'h0083);
      tick();
      drive("kbd_rd2", 0, 0, 15'h6000, 0, 0, 0, 0);
      chk16("kbd_ro", memory_in, 16'h0083);
      tick();
      drive("unmap", 0, 0, 15'h6001, 0, 0, 0, 0);
      chk16("unmap_rd", memory_in, 16'h0000);
      tick();

      // Reset with queued entries
      for (int i = 0; i < 3; i++) begin
         drive("q3", 0, 1, 15'(15'h4020 + i), 16'(16'h0AA0 + i), 0, 0, 0); tick();
      end
      drive("mid_rst", 1, 0, 15'h0005, 0, 1, 16'h0077, 0); tick();
      drive("post_rst", 0, 0, 15'h0005, 0, 0, 0, 0);
      chk1("pr_valid", scr_valid, 1'b0);
      chk1("pr_ovf", scr_overflow, 1'b0);
      chk16("pr_ram", memory_in, 16'h1234);
      tick();
      drive("post_rst_key", 0, 0, 15'h6000, 0, 0, 0, 0);
      chk16("pr_key", memory_in, 16'h0000);
      tick();

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic rdy;
         rdy = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         drive("rand", ($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), rand_addr(),
               16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom), rdy);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
